// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Two-master round-robin arbiter for the 32-bit classic-handshake
//            system bus. Holds the grant for the whole transfer. Decodes
//            adr[31:24] into one-hot slave strobes and returns the selected
//            slave's read data. Issues an error-ack for unmapped banks and
//            for slaves that never ack.
// Ports    : clk, rst_ni (sync, active-low)
//            m0_* : CPU master   (adr/dat/sel/we/stb in, ack/err/dat out)
//            m1_* : DMA master   (same set)
//            s_*  : slave side   (adr/dat/sel/we/stb[NSLV] out,
//                                 ack[NSLV]/dat[NSLV*32] in)
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
  parameter int NSLV    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_ni,
  input  logic [31:0]          m0_adr_i,
  input  logic [31:0]          m0_dat_i,
  input  logic [3:0]           m0_sel_i,
  input  logic                 m0_we_i,
  input  logic                 m0_stb_i,
  output logic                 m0_ack_o,
  output logic                 m0_err_o,
  output logic [31:0]          m0_dat_o,
  input  logic [31:0]          m1_adr_i,
  input  logic [31:0]          m1_dat_i,
  input  logic [3:0]           m1_sel_i,
  input  logic                 m1_we_i,
  input  logic                 m1_stb_i,
  output logic                 m1_ack_o,
  output logic                 m1_err_o,
  output logic [31:0]          m1_dat_o,
  output logic [31:0]          s_adr_o,
  output logic [31:0]          s_dat_o,
  output logic [3:0]           s_sel_o,
  output logic                 s_we_o,
  output logic [NSLV-1:0]      s_stb_o,
  input  logic [NSLV-1:0]      s_ack_i,
  input  logic [NSLV*32-1:0]   s_dat_i
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BUSY0 = 3'd1,
    ST_BUSY1 = 3'd2,
    ST_ERR0  = 3'd3,
    ST_ERR1  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             rr_last_q, rr_last_d;   // 1 = m1 was served last
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Working signals of the combinational block
  logic        pick_m1;
  logic [7:0]  req_bank;
  logic        sel_m1;
  logic [31:0] g_adr;
  logic        g_we;
  logic        g_stb;
  logic [7:0]  bank;
  logic        tmo;
  logic        ack_in;
  logic [31:0] rdat;
  logic        g_ack;
  logic        g_err;
  logic [31:0] g_dat;

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    cnt_d     = '0;
    pick_m1   = 1'b0;
    req_bank  = 8'd0;
    sel_m1    = 1'b0;
    g_adr     = 32'd0;
    g_we      = 1'b0;
    g_stb     = 1'b0;
    bank      = 8'd0;
    tmo       = 1'b0;
    ack_in    = 1'b0;
    rdat      = 32'd0;
    g_ack     = 1'b0;
    g_err     = 1'b0;
    g_dat     = 32'd0;
    s_adr_o   = 32'd0;
    s_dat_o   = 32'd0;
    s_sel_o   = 4'd0;
    s_we_o    = 1'b0;
    s_stb_o   = '0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m0_dat_o  = 32'd0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    m1_dat_o  = 32'd0;

    case (state_q)
      ST_IDLE: begin
        // On a tie the master that was not served last wins
        if (m0_stb_i && m1_stb_i) pick_m1 = ~rr_last_q;
        else                      pick_m1 = m1_stb_i;
        req_bank = pick_m1 ? m1_adr_i[31:24] : m0_adr_i[31:24];
        if (m0_stb_i || m1_stb_i) begin
          if ({24'd0, req_bank} < 32'(NSLV))
            state_d = pick_m1 ? ST_BUSY1 : ST_BUSY0;
          else
            state_d = pick_m1 ? ST_ERR1 : ST_ERR0;
        end
      end

      ST_BUSY0, ST_BUSY1: begin
        sel_m1  = (state_q == ST_BUSY1);
        g_adr   = sel_m1 ? m1_adr_i : m0_adr_i;
        g_we    = sel_m1 ? m1_we_i  : m0_we_i;
        g_stb   = sel_m1 ? m1_stb_i : m0_stb_i;
        s_adr_o = g_adr;
        s_dat_o = sel_m1 ? m1_dat_i : m0_dat_i;
        s_sel_o = sel_m1 ? m1_sel_i : m0_sel_i;
        s_we_o  = g_we;
        bank    = g_adr[31:24];
        tmo     = (cnt_q == CNT_LAST);
        for (int b = 0; b < NSLV; b++) begin
          if (bank == 8'(b)) begin
            ack_in     = s_ack_i[b];
            rdat       = s_dat_i[32*b +: 32];
            // Strobe drops in the timeout cycle so the slave sees the end
            s_stb_o[b] = g_stb & ~tmo;
          end
        end
        if (!g_stb) begin
          // Abort: master withdrew before any ack
          state_d   = ST_IDLE;
          rr_last_d = sel_m1;
        end else if (ack_in) begin
          // Ack wins over a coincident timeout
          g_ack     = 1'b1;
          g_dat     = g_we ? 32'd0 : rdat;
          state_d   = ST_IDLE;
          rr_last_d = sel_m1;
        end else if (tmo) begin
          g_ack     = 1'b1;
          g_err     = 1'b1;
          state_d   = ST_IDLE;
          rr_last_d = sel_m1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (sel_m1) begin
          m1_ack_o = g_ack;
          m1_err_o = g_err;
          m1_dat_o = g_dat;
        end else begin
          m0_ack_o = g_ack;
          m0_err_o = g_err;
          m0_dat_o = g_dat;
        end
      end

      ST_ERR0: begin
        m0_ack_o  = 1'b1;
        m0_err_o  = 1'b1;
        state_d   = ST_IDLE;
        rr_last_d = 1'b0;
      end

      ST_ERR1: begin
        m1_ack_o  = 1'b1;
        m1_err_o  = 1'b1;
        state_d   = ST_IDLE;
        rr_last_d = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      rr_last_q <= 1'b1;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Purpose  : Directed self-checking bench for bus_arbiter (NSLV=4,
//            TIMEOUT=64). Slaves 0, 1 and 3 ack combinationally from their
//            strobe; slave 2 never acks.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bus_arbiter;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic [31:0]  m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
  logic [3:0]   m0_sel_i, m1_sel_i;
  logic         m0_we_i, m0_stb_i, m1_we_i, m1_stb_i;
  logic         m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0]  m0_dat_o, m1_dat_o;
  logic [31:0]  s_adr_o, s_dat_o;
  logic [3:0]   s_sel_o;
  logic         s_we_o;
  logic [3:0]   s_stb_o;
  logic [3:0]   s_ack_i;
  logic [127:0] s_dat_i;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] D0 = 32'hAAAA_0000;
  localparam logic [31:0] D1 = 32'hBBBB_1111;
  localparam logic [31:0] D2 = 32'hCCCC_2222;
  localparam logic [31:0] D3 = 32'hDDDD_3333;

  assign s_ack_i = s_stb_o & 4'b1011;
  assign s_dat_i = {D3, D2, D1, D0};

  always #5 clk = ~clk;

  bus_arbiter #(.NSLV(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst_ni(rst_ni),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_we_i(m0_we_i), .m0_stb_i(m0_stb_i), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_we_i(m1_we_i), .m1_stb_i(m1_stb_i), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_stb_o(s_stb_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i)
  );

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    m0_adr_i = 32'd0; m0_dat_i = 32'd0; m0_sel_i = 4'd0; m0_we_i = 1'b0;
    m1_adr_i = 32'd0; m1_dat_i = 32'd0; m1_sel_i = 4'd0; m1_we_i = 1'b0;
    m0_stb_i = 1'b1; m1_stb_i = 1'b1;
    step(); step();
    @(negedge clk);
    checks++;
    if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_acks: got %b expected 0000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o});
    end
    checks++;
    if (s_stb_o !== 4'b0000 || s_adr_o !== 32'd0 || m0_dat_o !== 32'd0 || m1_dat_o !== 32'd0) begin
      failures++;
      $display("FAIL reset_bus: stb=%b adr=%h d0=%h d1=%h expected all 0", s_stb_o, s_adr_o, m0_dat_o, m1_dat_o);
    end
    step();
    m0_stb_i = 1'b0; m1_stb_i = 1'b0;
    rst_ni = 1'b1;
  endtask

  task automatic test_single_read();
    m0_adr_i = 32'h0000_0010; m0_sel_i = 4'hF; m0_we_i = 1'b0; m0_stb_i = 1'b1;
    @(negedge clk);
    checks++;
    if (s_stb_o !== 4'b0000 || m0_ack_o !== 1'b0) begin
      failures++;
      $display("FAIL rd_idle: stb=%b ack=%b expected 0000/0", s_stb_o, m0_ack_o);
    end
    step();
    @(negedge clk);
    checks++;
    if (s_stb_o !== 4'b0001) begin
      failures++;
      $display("FAIL rd_stb: got %b expected 0001", s_stb_o);
    end
    checks++;
    if (m0_ack_o !== 1'b1 || m0_err_o !== 1'b0 || m1_ack_o !== 1'b0) begin
      failures++;
      $display("FAIL rd_ack: ack=%b err=%b m1ack=%b expected 1/0/0", m0_ack_o, m0_err_o, m1_ack_o);
    end
    checks++;
    if (m0_dat_o !== D0) begin
      failures++;
      $display("FAIL rd_dat: got %h expected %h", m0_dat_o, D0);
    end
    checks++;
    if (s_adr_o !== 32'h0000_0010 || s_sel_o !== 4'hF || s_we_o !== 1'b0) begin
      failures++;
      $display("FAIL rd_fields: adr=%h sel=%h we=%b expected 00000010/f/0", s_adr_o, s_sel_o, s_we_o);
    end
    step();
    m0_stb_i = 1'b0;
    @(negedge clk);
    checks++;
    if (m0_ack_o !== 1'b0 || s_stb_o !== 4'b0000) begin
      failures++;
      $display("FAIL rd_after: ack=%b stb=%b expected 0/0000", m0_ack_o, s_stb_o);
    end
  endtask

  task automatic test_round_robin();
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    m0_adr_i = 32'h0100_0004; m0_we_i = 1'b0; m0_stb_i = 1'b1;
    m1_adr_i = 32'h0300_0008; m1_we_i = 1'b1; m1_dat_i = 32'h1234_5678;
    m1_sel_i = 4'h3; m1_stb_i = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0 || s_stb_o !== 4'b0010 || m0_dat_o !== D1) begin
      failures++;
      $display("FAIL rr_first: a0=%b a1=%b stb=%b d0=%h expected 1/0/0010/%h", m0_ack_o, m1_ack_o, s_stb_o, m0_dat_o, D1);
    end
    step();
    m0_stb_i = 1'b0;
    @(negedge clk);
    checks++;
    if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0 || s_stb_o !== 4'b0000) begin
      failures++;
      $display("FAIL rr_idle: a0=%b a1=%b stb=%b expected 0/0/0000", m0_ack_o, m1_ack_o, s_stb_o);
    end
    step();
    @(negedge clk);
    checks++;
    if (m1_ack_o !== 1'b1 || m1_err_o !== 1'b0 || s_stb_o !== 4'b1000 || m0_ack_o !== 1'b0) begin
      failures++;
      $display("FAIL rr_second: a1=%b e1=%b stb=%b a0=%b expected 1/0/1000/0", m1_ack_o, m1_err_o, s_stb_o, m0_ack_o);
    end
    checks++;
    if (s_we_o !== 1'b1 || s_dat_o !== 32'h1234_5678 || s_sel_o !== 4'h3 || m1_dat_o !== 32'd0) begin
      failures++;
      $display("FAIL rr_write: we=%b dat=%h sel=%h rd=%h expected 1/12345678/3/0", s_we_o, s_dat_o, s_sel_o, m1_dat_o);
    end
    // New tie right after m1's transfer: m0 must win
    step();
    m0_stb_i = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0 || s_stb_o !== 4'b0010) begin
      failures++;
      $display("FAIL rr_alternate: a0=%b a1=%b stb=%b expected 1/0/0010", m0_ack_o, m1_ack_o, s_stb_o);
    end
    step();
    m0_stb_i = 1'b0; m1_stb_i = 1'b0;
    step();
  endtask

  task automatic test_unmapped();
    m1_adr_i = 32'h0700_0000; m1_we_i = 1'b1; m1_stb_i = 1'b1;
    @(negedge clk);
    checks++;
    if (m1_ack_o !== 1'b0) begin
      failures++;
      $display("FAIL unm_idle: ack=%b expected 0", m1_ack_o);
    end
    step();
    @(negedge clk);
    checks++;
    if (m1_ack_o !== 1'b1 || m1_err_o !== 1'b1 || m1_dat_o !== 32'd0 || s_stb_o !== 4'b0000) begin
      failures++;
      $display("FAIL unm_err: ack=%b err=%b dat=%h stb=%b expected 1/1/0/0000", m1_ack_o, m1_err_o, m1_dat_o, s_stb_o);
    end
    step();
    m1_stb_i = 1'b0;
    @(negedge clk);
    checks++;
    if (m1_ack_o !== 1'b0 || m1_err_o !== 1'b0) begin
      failures++;
      $display("FAIL unm_after: ack=%b err=%b expected 0/0", m1_ack_o, m1_err_o);
    end
  endtask

  task automatic test_timeout();
    int early = 0;
    m0_adr_i = 32'h0200_0000; m0_we_i = 1'b0; m0_stb_i = 1'b1;
    step();
    // BUSY cycles 1..63 must keep the strobe up with no ack
    for (int k = 1; k < 64; k++) begin
      @(negedge clk);
      if (m0_ack_o !== 1'b0 || s_stb_o !== 4'b0100) early++;
      step();
    end
    checks++;
    if (early != 0) begin
      failures++;
      $display("FAIL tmo_wait: bad cycles=%0d expected 0", early);
    end
    @(negedge clk);
    checks++;
    if (m0_ack_o !== 1'b1 || m0_err_o !== 1'b1) begin
      failures++;
      $display("FAIL tmo_ack: ack=%b err=%b expected 1/1", m0_ack_o, m0_err_o);
    end
    checks++;
    if (s_stb_o !== 4'b0000 || m0_dat_o !== 32'd0) begin
      failures++;
      $display("FAIL tmo_bus: stb=%b dat=%h expected 0000/0", s_stb_o, m0_dat_o);
    end
    step();
    m0_stb_i = 1'b0;
    @(negedge clk);
    checks++;
    if (m0_ack_o !== 1'b0 || s_stb_o !== 4'b0000) begin
      failures++;
      $display("FAIL tmo_after: ack=%b stb=%b expected 0/0000", m0_ack_o, s_stb_o);
    end
  endtask

  task automatic test_reset_mid();
    m1_adr_i = 32'h0200_0040; m1_we_i = 1'b0; m1_stb_i = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (s_stb_o !== 4'b0100 || m1_ack_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_busy: stb=%b ack=%b expected 0100/0", s_stb_o, m1_ack_o);
    end
    step();
    rst_ni = 1'b0;
    step();
    @(negedge clk);
    checks++;
    if (s_stb_o !== 4'b0000 || m1_ack_o !== 1'b0 || m1_err_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_drop: stb=%b ack=%b err=%b expected 0000/0/0", s_stb_o, m1_ack_o, m1_err_o);
    end
    // Release with a tie pending: m0 wins after reset
    step();
    rst_ni = 1'b1;
    m0_adr_i = 32'h0000_0020; m0_we_i = 1'b0; m0_stb_i = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0 || s_stb_o !== 4'b0001) begin
      failures++;
      $display("FAIL rst_tie: a0=%b a1=%b stb=%b expected 1/0/0001", m0_ack_o, m1_ack_o, s_stb_o);
    end
    step();
    m0_stb_i = 1'b0; m1_stb_i = 1'b0;
    step();
  endtask

  task automatic test_abort();
    m0_adr_i = 32'h0200_0000; m0_we_i = 1'b0; m0_stb_i = 1'b1;
    step();
    m1_adr_i = 32'h0000_0100; m1_we_i = 1'b0; m1_stb_i = 1'b1;
    @(negedge clk);
    checks++;
    if (s_stb_o !== 4'b0100 || m1_ack_o !== 1'b0 || m1_dat_o !== 32'd0) begin
      failures++;
      $display("FAIL abt_busy: stb=%b a1=%b d1=%h expected 0100/0/0", s_stb_o, m1_ack_o, m1_dat_o);
    end
    step();
    m0_stb_i = 1'b0;
    @(negedge clk);
    checks++;
    if (s_stb_o !== 4'b0000 || m0_ack_o !== 1'b0 || m0_err_o !== 1'b0) begin
      failures++;
      $display("FAIL abt_drop: stb=%b ack=%b err=%b expected 0000/0/0", s_stb_o, m0_ack_o, m0_err_o);
    end
    step();
    @(negedge clk);
    checks++;
    if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0 || s_stb_o !== 4'b0000) begin
      failures++;
      $display("FAIL abt_idle: a0=%b a1=%b stb=%b expected 0/0/0000", m0_ack_o, m1_ack_o, s_stb_o);
    end
    step();
    @(negedge clk);
    checks++;
    if (m1_ack_o !== 1'b1 || s_stb_o !== 4'b0001 || m1_dat_o !== D0 || s_adr_o !== 32'h0000_0100) begin
      failures++;
      $display("FAIL abt_m1: a1=%b stb=%b d1=%h adr=%h expected 1/0001/%h/00000100", m1_ack_o, s_stb_o, m1_dat_o, s_adr_o, D0);
    end
    step();
    m1_stb_i = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_unmapped();
    test_timeout();
    test_reset_mid();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
